// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_LATENCY       = DIV_WIDTH_DEFAULT + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Start/busy/done divide request bundle between the execute stage and the divider.
// Handshake: start is sampled only while the divider is idle or in its done cycle;
// done is a one-cycle pulse and the results stay valid until the next accepted start.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract D.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        r_sh  = {r_in[WIDTH-1:0], q_in};
        diff  = r_sh - {1'b0, d};
        // A set r_in MSB means the shifted value exceeds any D, so the subtract must succeed.
        q_bit = r_in[WIDTH] | ~diff[WIDTH];
        r_out = q_bit ? diff : r_sh;
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle div/divu controller: PREP, WIDTH restoring steps, FIX, DONE pulse.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       bus,
    output div_state_e dbg_state
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   step_r;
    logic             step_q;
`ifdef DIV_SIGNED_EN
    logic             sop_q, sop_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
`else
    logic             signed_op_unused;
    assign signed_op_unused = bus.signed_op;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in (r_q),
        .q_in (qs_q[WIDTH-1]),
        .d    (d_q),
        .r_out(step_r),
        .q_bit(step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        qs_d    = qs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sop_d   = sop_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = PREP;
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
`ifdef DIV_SIGNED_EN
                    sop_d   = bus.signed_op;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
`ifdef DIV_SIGNED_EN
                neg_r_d = sop_q & a_q[WIDTH-1];
                neg_q_d = (sop_q & a_q[WIDTH-1]) ^ (sop_q & b_q[WIDTH-1]);
                qs_d    = (sop_q & a_q[WIDTH-1]) ? -a_q : a_q;
                d_d     = (sop_q & b_q[WIDTH-1]) ? -b_q : b_q;
`else
                qs_d    = a_q;
                d_d     = b_q;
`endif
                r_d     = '0;
                cnt_d   = CW'(WIDTH - 1);
                dz_d    = (b_q == '0);
                state_d = ITER;
            end
            ITER: begin
                r_d  = step_r;
                qs_d = {qs_q[WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                // Divide by zero reports the untouched dividend, never the iterated value.
                if (dz_q) begin
                    quo_d = '1;
                    rem_d = a_q;
                    dbz_d = 1'b1;
                end else begin
`ifdef DIV_SIGNED_EN
                    quo_d = neg_q_q ? -qs_q : qs_q;
                    rem_d = neg_r_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
`else
                    quo_d = qs_q;
                    rem_d = r_q[WIDTH-1:0];
`endif
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            qs_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sop_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            qs_q    <= qs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sop_q   <= sop_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign bus.busy        = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table, random back-to-back ops,
// handshake and asynchronous reset corner cases, scoreboard on the done pulse.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int W   = DIV_WIDTH_DEFAULT;
    localparam int LAT = DIV_LATENCY;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic         sop;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    div_state_e dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         busy_cnt = 0;

    logic [2*W:0] exp_q[$];
    int           start_q[$];
    vec_t         vecs[13];

    div_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, q64, r64;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sop && SIGNED_EN) begin
            sa  = $signed(a);
            sb  = $signed(b);
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[W-1:0];
            r   = r64[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // driver: call at a negedge; returns just after the accepting edge
    task automatic issue(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        bus.signed_op = sop;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({eq, er, edz});
        start_q.push_back(cyc);
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.signed_op = 1'($urandom_range(0, 1));
    endtask

    // returns at the negedge inside the done cycle
    task automatic wait_done();
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: no done within %0d cycles", LAT + 8);
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           s;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("done_without_request", W'(exp_q.size()), W'(1));
                end else begin
                    e = exp_q.pop_front();
                    s = start_q.pop_front();
                    check("quotient", bus.quotient, e[2*W:W+1]);
                    check("remainder", bus.remainder, e[W:1]);
                    check("div_by_zero", W'(bus.div_by_zero), W'(e[0]));
                    check("latency", W'(cyc - s), W'(LAT));
                    check("busy_cycles", W'(busy_cnt), W'(LAT));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         sop, edz;

        vecs[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,
                     SIGNED_EN ? 32'hFFFFFFF2 : 32'h24924916,
                     SIGNED_EN ? 32'hFFFFFFFE : 32'h00000002, 1'b0};
        vecs[2]  = '{1'b0, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'h00000002, 1'b0};
        vecs[3]  = '{1'b0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1'b1};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                     SIGNED_EN ? 32'h80000000 : 32'h00000000,
                     SIGNED_EN ? 32'h00000000 : 32'h80000000, 1'b0};
        vecs[5]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{1'b1, 32'd100, 32'hFFFFFFF9,
                     SIGNED_EN ? 32'hFFFFFFF2 : 32'h00000000,
                     SIGNED_EN ? 32'h00000002 : 32'd100, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1};
        vecs[8]  = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[9]  = '{1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,
                     SIGNED_EN ? 32'h00000003 : 32'h00000000,
                     SIGNED_EN ? 32'hFFFFFFFF : 32'hFFFFFFF9, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};

        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_quotient", bus.quotient, '0);
        check("rst_remainder", bus.remainder, '0);
        check("rst_dbz", W'(bus.div_by_zero), W'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", W'(dbg_state), W'(IDLE));

        // vector table, one op at a time, outputs held afterwards
        foreach (vecs[i]) begin
            issue(vecs[i].sop, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz);
            wait_done();
            @(negedge clk);
            check("hold_quotient", bus.quotient, vecs[i].eq);
            check("hold_remainder", bus.remainder, vecs[i].er);
            check("hold_done_low", W'(bus.done), W'(0));
        end

        // random back-to-back ops, each started in the previous done cycle
        for (int i = 0; i < 16; i++) begin
            a   = $urandom;
            b   = (i % 5 == 0) ? W'($urandom_range(0, 15)) : $urandom;
            sop = 1'($urandom_range(0, 1));
            ref_div(sop, a, b, eq, er, edz);
            issue(sop, a, b, eq, er, edz);
            wait_done();
        end
        @(negedge clk);
        check("b2b_end_idle", W'(dbg_state), W'(IDLE));

        // start while busy is ignored; start in DONE is accepted
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        bus.dividend  = 32'd55;
        bus.divisor   = 32'd5;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        check("ignored_start_state", W'(dbg_state), W'(ITER));
        wait_done();
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_done();
        @(negedge clk);

        // asynchronous reset in ITER with counter at 20
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done();
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        check("pre_reset_busy", W'(bus.busy), W'(1));
        check("pre_reset_quotient", bus.quotient, 32'd14);
        rst = 1'b1;
        #1;
        check("async_rst_busy", W'(bus.busy), W'(0));
        check("async_rst_done", W'(bus.done), W'(0));
        check("async_rst_quotient", bus.quotient, '0);
        check("async_rst_remainder", bus.remainder, '0);
        check("async_rst_dbz", W'(bus.div_by_zero), W'(0));
        check("async_rst_state", W'(dbg_state), W'(IDLE));
        exp_q.delete();
        start_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done();
        @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
